// File: rtl/genius_pkg.sv
// Shared definitions for the countdown timer and the game controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package genius_pkg;

  // Default largest load value: one BCD digit.
  localparam int unsigned MAX_VAL_DEFAULT = 9;

  // Countdown FSM encoding, also decoded by the game controller.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } timer_state_t;

  // Clamp a requested load value to the largest legal count.
  function automatic logic [3:0] sat_load(input logic [3:0] val,
                                          input logic [3:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/bcd_down_cnt.sv
// Single-digit loadable down counter; never wraps below zero.
// Latency: load/dec take effect at the next CLK1 rising edge.
// Backpressure: none; dec at zero is ignored.
// Ports: CLK1 clock, R sync active-high reset, load/load_val parallel load
//        (load wins over dec), dec decrement strobe, value current count,
//        is_one high when value == 1.
module bcd_down_cnt (
  input  logic       CLK1,
  input  logic       R,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] value,
  output logic       is_one
);

  always_ff @(posedge CLK1) begin
    if (R) begin
      value <= 4'd0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != 4'd0)) begin
      value <= value - 4'd1;
    end
  end

  assign is_one = (value == 4'd1);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: load a digit on start, decrement on each E tick, flag end.
// Latency: inputs sampled at edge N show on outputs right after edge N.
// Backpressure: none; pause freezes the count, start always restarts it.
// Ports: CLK1 clock, R sync active-high reset, start load strobe, load_val
//        start value, E tick enable, pause freeze level, tempo remaining
//        count, end_time one-cycle end pulse, running/done state flags.
module countdown_timer
  import genius_pkg::*;
#(
  parameter int unsigned MAX_VAL = MAX_VAL_DEFAULT
) (
  input  logic       CLK1,
  input  logic       R,
  input  logic       start,
  input  logic [3:0] load_val,
  input  logic       E,
  input  logic       pause,
  output logic [3:0] tempo,
  output logic       end_time,
  output logic       running,
  output logic       done
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_VAL);

  timer_state_t state, state_nxt;
  logic         cnt_load;
  logic         cnt_dec;
  logic         cnt_is_one;
  logic [3:0]   load_sat;
  logic         end_nxt;

  assign load_sat = sat_load(load_val, MAX_CNT);

  bcd_down_cnt u_cnt (
    .CLK1     (CLK1),
    .R        (R),
    .load     (cnt_load),
    .load_val (load_sat),
    .dec      (cnt_dec),
    .value    (tempo),
    .is_one   (cnt_is_one)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    end_nxt   = 1'b0;
    if (start) begin
      // start overrides E and pause in every state.
      cnt_load = 1'b1;
      if (load_sat == 4'd0) begin
        state_nxt = ST_DONE;
        end_nxt   = 1'b1;
      end else begin
        state_nxt = ST_RUN;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (pause) begin
            state_nxt = ST_PAUSED;
          end else if (E) begin
            cnt_dec = 1'b1;
            if (cnt_is_one) begin
              state_nxt = ST_DONE;
              end_nxt   = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) state_nxt = ST_RUN;
        end
        default: ;
      endcase
    end
    // A zero-load start right after an end pulse must not stretch the pulse.
    if (end_time) end_nxt = 1'b0;
  end

  always_ff @(posedge CLK1) begin
    if (R) begin
      state    <= ST_IDLE;
      end_time <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      end_time <= end_nxt;
      running  <= (state_nxt == ST_RUN);
      done     <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic       CLK1 = 1'b0;
  logic       R = 1'b1;
  logic       start = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       E = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] tempo;
  logic       end_time;
  logic       running;
  logic       done;

  int checks = 0;
  int failures = 0;
  int end_cnt = 0;

  countdown_timer #(.MAX_VAL(9)) dut (
    .CLK1     (CLK1),
    .R        (R),
    .start    (start),
    .load_val (load_val),
    .E        (E),
    .pause    (pause),
    .tempo    (tempo),
    .end_time (end_time),
    .running  (running),
    .done     (done)
  );

  always #5 CLK1 = ~CLK1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs sampled 1 time unit later, end pulses counted.
  task automatic step();
    @(posedge CLK1);
    #1;
    if (end_time === 1'b1) end_cnt++;
  endtask

  task automatic do_start(input logic [3:0] v);
    start = 1'b1;
    load_val = v;
    step();
    start = 1'b0;
  endtask

  // Three quiet cycles, then one cycle with E high.
  task automatic slow_tick();
    E = 1'b0;
    repeat (3) step();
    E = 1'b1;
    step();
    E = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Reset
    step();
    chk("rst_tempo", tempo, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_end", end_time, 0);
    R = 1'b0;
    step();
    chk("idle_tempo", tempo, 0);

    // Load 3, tick every 4th cycle
    end_cnt = 0;
    do_start(4'd3);
    chk("t31_load", tempo, 3);
    chk("t31_running", running, 1);
    slow_tick();
    chk("t31_tick1", tempo, 2);
    slow_tick();
    chk("t31_tick2", tempo, 1);
    chk("t31_noend", end_time, 0);
    slow_tick();
    chk("t31_tick3", tempo, 0);
    chk("t31_end", end_time, 1);
    chk("t31_done", done, 1);
    chk("t31_notrun", running, 0);
    E = 1'b1; pause = 1'b1;
    step();
    chk("t31_end_low", end_time, 0);
    chk("t31_done_hold", done, 1);
    chk("t31_tempo_hold", tempo, 0);
    E = 1'b0; pause = 1'b0;
    chk("t31_endcnt", end_cnt, 1);

    // Saturating load
    end_cnt = 0;
    do_start(4'd12);
    chk("t32_sat", tempo, 9);
    E = 1'b1;
    repeat (8) step();
    chk("t32_at1", tempo, 1);
    chk("t32_noend", end_cnt, 0);
    step();
    chk("t32_zero", tempo, 0);
    chk("t32_done", done, 1);
    step();
    E = 1'b0;
    chk("t32_endcnt", end_cnt, 1);

    // Pause
    do_start(4'd5);
    E = 1'b1;
    step();
    step();
    chk("t33_pre", tempo, 3);
    pause = 1'b1;
    step();
    chk("t33_pause_tempo", tempo, 3);
    chk("t33_pause_run", running, 0);
    repeat (3) step();
    chk("t33_frozen", tempo, 3);
    pause = 1'b0; E = 1'b0;
    step();
    chk("t33_resume_run", running, 1);
    chk("t33_resume_tempo", tempo, 3);
    E = 1'b1;
    step();
    E = 1'b0;
    chk("t33_after", tempo, 2);

    // Reset mid-run
    end_cnt = 0;
    do_start(4'd4);
    E = 1'b1;
    step();
    chk("t34_tick", tempo, 3);
    R = 1'b1;
    step();
    R = 1'b0;
    chk("t34_tempo", tempo, 0);
    chk("t34_running", running, 0);
    chk("t34_done", done, 0);
    repeat (3) step();
    E = 1'b0;
    chk("t34_idle_tempo", tempo, 0);
    chk("t34_idle_run", running, 0);
    chk("t34_endcnt", end_cnt, 0);

    // Zero load, then re-arm from DONE
    end_cnt = 0;
    do_start(4'd0);
    chk("t35_end", end_time, 1);
    chk("t35_done", done, 1);
    chk("t35_tempo", tempo, 0);
    step();
    chk("t35_end_low", end_time, 0);
    chk("t35_endcnt", end_cnt, 1);
    do_start(4'd2);
    chk("t35_run", running, 1);
    chk("t35_rearm", tempo, 2);
    chk("t35_notdone", done, 0);

    // Restart at tempo=1 beats the final tick
    end_cnt = 0;
    E = 1'b1;
    step();
    chk("t36_at1", tempo, 1);
    start = 1'b1; load_val = 4'd6;
    step();
    start = 1'b0;
    chk("t36_reload", tempo, 6);
    chk("t36_noend", end_time, 0);
    chk("t36_run", running, 1);
    step();
    E = 1'b0;
    chk("t36_next", tempo, 5);
    chk("t36_endcnt", end_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
